// File: rtl/trigger_edge_arbiter.sv
// Rising-edge detector and timestamper for external trigger pins.
// Pending edges are round-robin arbitrated onto one valid/ready event port.
module trigger_edge_arbiter #(
    parameter int N_INPUTS    = 8,
    parameter int TS_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear_pending,
    input  logic [N_INPUTS-1:0]         trig_in,
    input  logic                        evt_ready,
    output logic                        evt_valid,
    output logic [$clog2(N_INPUTS)-1:0] evt_channel,
    output logic [TS_WIDTH-1:0]         evt_timestamp,
    output logic [N_INPUTS-1:0]         pending,
    output logic [N_INPUTS-1:0]         overflow
);

    localparam int CW = $clog2(N_INPUTS);
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);
    localparam logic [CW:0]   NUM  = (CW+1)'(N_INPUTS);

    logic [TS_WIDTH-1:0] ts_counter;
    logic [N_INPUTS-1:0] sync_q [SYNC_STAGES];
    logic [N_INPUTS-1:0] sync_out;
    logic [N_INPUTS-1:0] prev_q;
    logic [N_INPUTS-1:0] rise;
    logic [TS_WIDTH-1:0] ts_cap [N_INPUTS];
    logic [N_INPUTS-1:0] pending_d;
    logic [N_INPUTS-1:0] overflow_d;
    logic [N_INPUTS-1:0] cap_en;
    logic [N_INPUTS-1:0] grant;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       sel;
    logic                found;
    logic                slot_free;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign rise      = sync_out & ~prev_q & {N_INPUTS{enable}};
    assign slot_free = ~evt_valid | evt_ready;

    // Free-running timestamp; wraps naturally and ignores enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_counter <= '0;
        end else begin
            ts_counter <= ts_counter + 1'b1;
        end
    end

    // Synchroniser chain plus previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= trig_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_out;
        end
    end

    // Round-robin search of registered pending, starting at rr_ptr.
    always_comb begin
        logic [CW:0] idx;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!found && pending[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    // One-hot grant for the channel loaded into the output slot.
    always_comb begin
        grant = '0;
        if (slot_free && found) begin
            grant[sel] = 1'b1;
        end
    end

    // Next pending/overflow state and timestamp capture enables.
    always_comb begin
        pending_d  = pending;
        overflow_d = overflow;
        cap_en     = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant[i]) begin
                pending_d[i] = 1'b0;
            end
            if (rise[i]) begin
                if (!pending[i] || grant[i]) begin
                    pending_d[i] = 1'b1;
                    cap_en[i]    = 1'b1;
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
        if (clear_pending) begin
            pending_d  = '0;
            overflow_d = '0;
        end
    end

    // Pending and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    // Per-channel captured timestamps; only meaningful while pending.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_INPUTS; i++) begin
            if (cap_en[i]) begin
                ts_cap[i] <= ts_counter;
            end
        end
    end

    // Output slot: load a new event whenever the slot is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid     <= 1'b0;
            evt_channel   <= '0;
            evt_timestamp <= '0;
            rr_ptr        <= '0;
        end else if (slot_free) begin
            if (found) begin
                evt_valid     <= 1'b1;
                evt_channel   <= sel;
                evt_timestamp <= ts_cap[sel];
                rr_ptr        <= (sel == LAST) ? '0 : sel + 1'b1;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trigger_edge_arbiter.sv
// Directed bench for trigger_edge_arbiter (N=8, TS=32, SYNC=2).
// Inputs change 1 time unit after posedge; outputs are read there too.
module tb_trigger_edge_arbiter;

    localparam int N  = 8;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear_pending;
    logic [N-1:0]  trig_in;
    logic          evt_ready;
    logic          evt_valid;
    logic [2:0]    evt_channel;
    logic [TW-1:0] evt_timestamp;
    logic [N-1:0]  pending;
    logic [N-1:0]  overflow;

    int n_checks = 0;
    int n_fail   = 0;

    trigger_edge_arbiter #(
        .N_INPUTS(N),
        .TS_WIDTH(TW),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .clear_pending(clear_pending),
        .trig_in(trig_in),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_channel(evt_channel),
        .evt_timestamp(evt_timestamp),
        .pending(pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b1;
        clear_pending = 1'b0;
        trig_in = '0;
        evt_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (evt_valid !== 1'b0 || pending !== 8'h00 || overflow !== 8'h00 ||
            evt_channel !== 3'd0 || evt_timestamp !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: v=%b p=%h o=%h ch=%0d ts=%0d want all 0",
                     evt_valid, pending, overflow, evt_channel, evt_timestamp);
        end
    endtask

    task automatic test_single();
        do_reset();
        trig_in[3] = 1'b1;
        step();
        step();
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_early: pending=%h want 00", pending);
        end
        step();
        n_checks++;
        if (pending !== 8'h08 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend: p=%h v=%b want 08/0", pending, evt_valid);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd3 ||
            evt_timestamp !== 32'd2 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL single_evt: v=%b ch=%0d ts=%0d p=%h want 1/3/2/00",
                     evt_valid, evt_channel, evt_timestamp, pending);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: v=%b want 0", evt_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch [3];
        exp_ch[0] = 3'd0;
        exp_ch[1] = 3'd5;
        exp_ch[2] = 3'd7;
        do_reset();
        trig_in = 8'hA1;
        step();
        step();
        step();
        n_checks++;
        if (pending !== 8'hA1) begin
            n_fail++;
            $display("FAIL rr_pend: pending=%h want a1", pending);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_channel !== exp_ch[e] ||
                evt_timestamp !== 32'd2) begin
                n_fail++;
                $display("FAIL rr_evt%0d: v=%b ch=%0d ts=%0d want 1/%0d/2",
                         e, evt_valid, evt_channel, evt_timestamp, exp_ch[e]);
            end
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL rr_end: v=%b p=%h want 0/00", evt_valid, pending);
        end
        trig_in = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        evt_ready = 1'b0;
        trig_in[2] = 1'b1;
        step();
        step();
        trig_in[2] = 1'b0;
        step();
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd2 ||
            evt_timestamp !== 32'd2 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_first: v=%b ch=%0d ts=%0d p=%h want 1/2/2/00",
                     evt_valid, evt_channel, evt_timestamp, pending);
        end
        trig_in[2] = 1'b1;
        step();
        step();
        trig_in[2] = 1'b0;
        step();
        n_checks++;
        if (pending !== 8'h04 || overflow !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_second: p=%h o=%h want 04/00", pending, overflow);
        end
        step();
        trig_in[2] = 1'b1;
        step();
        step();
        trig_in[2] = 1'b0;
        step();
        n_checks++;
        if (pending !== 8'h04 || overflow !== 8'h04) begin
            n_fail++;
            $display("FAIL bp_third: p=%h o=%h want 04/04", pending, overflow);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_channel !== 3'd2 ||
                evt_timestamp !== 32'd2) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b ch=%0d ts=%0d want 1/2/2",
                         c, evt_valid, evt_channel, evt_timestamp);
            end
        end
        evt_ready = 1'b1;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd2 ||
            evt_timestamp !== 32'd6 || pending !== 8'h00 ||
            overflow !== 8'h04) begin
            n_fail++;
            $display("FAIL bp_queued: v=%b ch=%0d ts=%0d p=%h o=%h want 1/2/6/00/04",
                     evt_valid, evt_channel, evt_timestamp, pending, overflow);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: v=%b want 0", evt_valid);
        end
        clear_pending = 1'b1;
        step();
        clear_pending = 1'b0;
        n_checks++;
        if (overflow !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_clear: overflow=%h want 00", overflow);
        end
    endtask

    task automatic test_clear_wins();
        do_reset();
        trig_in[6] = 1'b1;
        step();
        step();
        clear_pending = 1'b1;
        step();
        clear_pending = 1'b0;
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_pend: pending=%h want 00", pending);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_evt: v=%b want 0", evt_valid);
        end
        trig_in = '0;
    endtask

    task automatic test_fairness();
        int ch1_cnt;
        int ch2_cnt;
        int ch2_first;
        int other_cnt;
        ch1_cnt = 0;
        ch2_cnt = 0;
        ch2_first = -1;
        other_cnt = 0;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            trig_in[1] = ((k % 4) < 2);
            trig_in[2] = (k >= 1);
            step();
            if (evt_valid === 1'b1) begin
                if (evt_channel === 3'd1) begin
                    ch1_cnt++;
                end else if (evt_channel === 3'd2) begin
                    ch2_cnt++;
                    if (ch2_first < 0) ch2_first = k;
                end else begin
                    other_cnt++;
                end
            end
        end
        n_checks++;
        if (ch1_cnt != 6 || other_cnt != 0) begin
            n_fail++;
            $display("FAIL fair_ch1: ch1=%0d other=%0d want 6/0", ch1_cnt, other_cnt);
        end
        n_checks++;
        if (ch2_cnt != 1 || ch2_first != 4) begin
            n_fail++;
            $display("FAIL fair_ch2: cnt=%0d first=%0d want 1/4", ch2_cnt, ch2_first);
        end
        trig_in = '0;
    endtask

    task automatic test_enable();
        int bad;
        do_reset();
        enable = 1'b0;
        trig_in[4] = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (evt_valid !== 1'b0 || pending !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_off: bad_cycles=%0d want 0", bad);
        end
        enable = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (evt_valid !== 1'b0 || pending !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_high: bad_cycles=%0d want 0", bad);
        end
        trig_in[4] = 1'b0;
        step();
        step();
        step();
        trig_in[4] = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (pending !== 8'h10) begin
            n_fail++;
            $display("FAIL en_clean: pending=%h want 10", pending);
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd4 || pending !== 8'h00) begin
            n_fail++;
            $display("FAIL en_drain: v=%b ch=%0d p=%h want 1/4/00",
                     evt_valid, evt_channel, pending);
        end
        enable = 1'b1;
        trig_in = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        evt_ready = 1'b0;
        trig_in = 8'hA5;
        step();
        step();
        trig_in = '0;
        step();
        step();
        trig_in = 8'hA5;
        step();
        step();
        trig_in = '0;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd0 ||
            pending !== 8'hA5 || overflow !== 8'hA4) begin
            n_fail++;
            $display("FAIL mr_setup: v=%b ch=%0d p=%h o=%h want 1/0/a5/a4",
                     evt_valid, evt_channel, pending, overflow);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0 || evt_channel !== 3'd0 ||
            evt_timestamp !== 32'd0 || pending !== 8'h00 ||
            overflow !== 8'h00) begin
            n_fail++;
            $display("FAIL mr_zero: v=%b ch=%0d ts=%0d p=%h o=%h want all 0",
                     evt_valid, evt_channel, evt_timestamp, pending, overflow);
        end
        evt_ready = 1'b1;
        trig_in[3] = 1'b1;
        step();
        step();
        step();
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_channel !== 3'd3 ||
            evt_timestamp !== 32'd2) begin
            n_fail++;
            $display("FAIL mr_ts: v=%b ch=%0d ts=%0d want 1/3/2",
                     evt_valid, evt_channel, evt_timestamp);
        end
        trig_in = '0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        clear_pending = 1'b0;
        trig_in = '0;
        evt_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_clear_wins();
        test_fairness();
        test_enable();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
